// File: rtl/noc_pkg.sv
// Shared NoC router constants, port indices and the crossbar select encoding
// used by the switch allocator and its interface.
package noc_pkg;

    localparam int N_PORTS = 5;
    localparam int PORT_W  = 3;
    localparam int SEL_W   = 6;

    typedef logic [PORT_W-1:0] port_t;
    typedef logic [SEL_W-1:0]  sel_t;

    localparam port_t LOCAL = 3'd0;
    localparam port_t N     = 3'd1;
    localparam port_t E     = 3'd2;
    localparam port_t S     = 3'd3;
    localparam port_t W     = 3'd4;

    // Out-of-range select value; the crossbar drives its default on it.
    localparam sel_t SEL_IDLE = SEL_W'(25);

    function automatic sel_t sel_encode(input port_t outPort, input port_t inPort);
        return SEL_W'(outPort) * SEL_W'(N_PORTS) + SEL_W'(inPort);
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant/select bundle between the input buffers, the switch allocator
// and the crossbar.
interface switch_allocator_if;
    import noc_pkg::*;

    logic [N_PORTS-1:0]        req_valid;
    logic [PORT_W*N_PORTS-1:0] req_port;
    logic [N_PORTS-1:0]        req_tail;
    logic [N_PORTS-1:0]        grant;
    logic [SEL_W-1:0]          sel;
    logic                      sel_valid;
    logic                      err;

    modport master (
        output req_valid, req_port, req_tail,
        input  grant, sel, sel_valid, err
    );

    modport slave (
        input  req_valid, req_port, req_tail,
        output grant, sel, sel_valid, err
    );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// N-input round-robin arbiter: the first set request at or after the pointer
// (wrapping) receives a one-hot grant.
module rr_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int PTR_W   = 3
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant
);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator for the 5-port router: one round-robin grant per
// cycle, per-output packet locks, registered crossbar select.
// Optional sticky illegal-destination flag: define SWITCH_ALLOC_ERR_EN.
module switch_allocator
    import noc_pkg::*;
(
    input logic               clk,
    input logic               rst,
    switch_allocator_if.slave bus
);

    logic [N_PORTS-1:0] w_legal;
    logic [N_PORTS-1:0] w_elig;
    logic [N_PORTS-1:0] w_grant;
    logic [PORT_W-1:0]  w_dest;
    logic [PORT_W-1:0]  w_gIdx;
    logic [PORT_W-1:0]  w_gPort;
    logic               w_anyGrant;

    logic [PORT_W-1:0]  r_rrPtr;
    logic [N_PORTS-1:0] r_locked;
    logic [PORT_W-1:0]  r_owner [N_PORTS];
    logic [SEL_W-1:0]   r_sel;
    logic               r_selValid;

    // Eligibility looks only at registered locks, so a lock released this
    // cycle frees its output for other inputs from the next cycle on.
    always_comb begin
        w_legal = '0;
        w_elig  = '0;
        w_dest  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_dest     = bus.req_port[i*PORT_W +: PORT_W];
            w_legal[i] = (w_dest < PORT_W'(N_PORTS));
            if (!rst && bus.req_valid[i] && w_legal[i])
                w_elig[i] = !r_locked[w_dest] || (r_owner[w_dest] == PORT_W'(i));
        end
    end

    rr_arbiter #(
        .NUM_REQ (N_PORTS),
        .PTR_W   (PORT_W)
    ) u_arb (
        .i_req   (w_elig),
        .i_ptr   (r_rrPtr),
        .o_grant (w_grant)
    );

    always_comb begin
        w_gIdx = '0;
        for (int i = 0; i < N_PORTS; i++)
            if (w_grant[i]) w_gIdx = PORT_W'(i);
    end

    assign w_anyGrant = |w_grant;
    assign w_gPort    = bus.req_port[w_gIdx*PORT_W +: PORT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rrPtr    <= '0;
            r_locked   <= '0;
            for (int i = 0; i < N_PORTS; i++) r_owner[i] <= '0;
            r_sel      <= SEL_IDLE;
            r_selValid <= 1'b0;
        end else if (w_anyGrant) begin
            r_rrPtr <= (w_gIdx == PORT_W'(N_PORTS - 1)) ? '0 : w_gIdx + 1'b1;
            if (bus.req_tail[w_gIdx]) begin
                r_locked[w_gPort] <= 1'b0;
            end else if (!r_locked[w_gPort]) begin
                r_locked[w_gPort] <= 1'b1;
                r_owner[w_gPort]  <= w_gIdx;
            end
            r_sel      <= sel_encode(w_gPort, w_gIdx);
            r_selValid <= 1'b1;
        end else begin
            r_sel      <= SEL_IDLE;
            r_selValid <= 1'b0;
        end
    end

    assign bus.grant     = w_grant;
    assign bus.sel       = r_sel;
    assign bus.sel_valid = r_selValid;

`ifdef SWITCH_ALLOC_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (|(bus.req_valid & ~w_legal))
            r_err <= 1'b1;
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Table-driven bench for switch_allocator: grant checked in-cycle, registered
// select/err checked next cycle through a scoreboard queue.
module tb_switch_allocator;
    import noc_pkg::*;

`ifdef SWITCH_ALLOC_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    typedef struct {
        logic [4:0]  valid;
        logic [14:0] port;
        logic [4:0]  tail;
        logic [4:0]  expGrant;
        logic [5:0]  expSel;
        logic        expSelValid;
        logic        expErr;
        string       name;
    } vec_t;

    typedef struct {
        logic [5:0] sel;
        logic       selValid;
        logic       err;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecCount  = 0;
    int   missCount = 0;
    vec_t vecs[$];
    exp_t sbQ[$];

    switch_allocator_if bus();

    switch_allocator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] pp(input int p0, input int p1, input int p2,
                                       input int p3, input int p4);
        return {3'(p4), 3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Checks last cycle's registered outputs, drives this cycle, checks grant.
    task automatic applyStimulus(input logic rstVal, input logic [4:0] valid,
                                 input logic [14:0] port, input logic [4:0] tail,
                                 input logic [4:0] expGrant, input logic [5:0] expSel,
                                 input logic expSelValid, input logic expErr,
                                 input string name);
        exp_t e;
        @(negedge clk);
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput({e.name, " sel"}, 32'(bus.sel), 32'(e.sel));
            checkOutput({e.name, " sel_valid"}, 32'(bus.sel_valid), 32'(e.selValid));
            checkOutput({e.name, " err"}, 32'(bus.err), 32'(e.err));
        end
        rst           = rstVal;
        bus.req_valid = valid;
        bus.req_port  = port;
        bus.req_tail  = tail;
        #1;
        checkOutput({name, " grant"}, 32'(bus.grant), 32'(expGrant));
        sbQ.push_back('{expSel, expSelValid, expErr & ERR_ON, name});
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_port  = '0;
        bus.req_tail  = '0;

        vecs.push_back('{5'b00100, pp(0,0,4,0,0), 5'b00100, 5'b00100, 6'd22, 1'b1, 1'b0, "single2to4"});
        vecs.push_back('{5'b00001, pp(4,0,0,0,0), 5'b00000, 5'b00001, 6'd20, 1'b1, 1'b0, "head0to4"});
        vecs.push_back('{5'b00001, pp(4,0,0,0,0), 5'b00001, 5'b00001, 6'd20, 1'b1, 1'b0, "tail0to4"});
        for (int r = 0; r < 2; r++) begin
            vecs.push_back('{5'b01011, pp(1,2,0,3,0), 5'b01011, 5'b00010, 6'd11, 1'b1, 1'b0, "rr1"});
            vecs.push_back('{5'b01011, pp(1,2,0,3,0), 5'b01011, 5'b01000, 6'd18, 1'b1, 1'b0, "rr3"});
            vecs.push_back('{5'b01011, pp(1,2,0,3,0), 5'b01011, 5'b00001, 6'd5,  1'b1, 1'b0, "rr0"});
        end
        vecs.push_back('{5'b00010, pp(0,2,0,0,0), 5'b00000, 5'b00010, 6'd11, 1'b1, 1'b0, "lockHead1"});
        vecs.push_back('{5'b01010, pp(0,2,0,2,0), 5'b01000, 5'b00010, 6'd11, 1'b1, 1'b0, "lockBody1"});
        vecs.push_back('{5'b01010, pp(0,2,0,2,0), 5'b01010, 5'b00010, 6'd11, 1'b1, 1'b0, "lockTail1"});
        vecs.push_back('{5'b01000, pp(0,0,0,2,0), 5'b01000, 5'b01000, 6'd13, 1'b1, 1'b0, "after3"});
        vecs.push_back('{5'b10000, pp(0,0,0,0,0), 5'b00000, 5'b10000, 6'd4,  1'b1, 1'b0, "lock0by4"});
        vecs.push_back('{5'b00101, pp(3,0,0,0,0), 5'b00101, 5'b00001, 6'd15, 1'b1, 1'b0, "bypass"});
        vecs.push_back('{5'b00100, pp(0,0,0,0,0), 5'b00100, 5'b00000, 6'd25, 1'b0, 1'b0, "blocked2"});
        vecs.push_back('{5'b10100, pp(0,0,0,0,0), 5'b10100, 5'b10000, 6'd4,  1'b1, 1'b0, "skipTo4"});
        vecs.push_back('{5'b00100, pp(0,0,0,0,0), 5'b00100, 5'b00100, 6'd2,  1'b1, 1'b0, "freed2"});
        vecs.push_back('{5'b11111, pp(0,1,2,3,4), 5'b11111, 5'b01000, 6'd18, 1'b1, 1'b0, "all3"});
        vecs.push_back('{5'b11111, pp(0,1,2,3,4), 5'b11111, 5'b10000, 6'd24, 1'b1, 1'b0, "all4"});
        vecs.push_back('{5'b00001, pp(6,0,0,0,0), 5'b00001, 5'b00000, 6'd25, 1'b0, 1'b1, "illegal6"});
        vecs.push_back('{5'b01010, pp(0,5,0,1,0), 5'b01010, 5'b01000, 6'd8,  1'b1, 1'b1, "illegal5"});
        vecs.push_back('{5'b00000, pp(0,0,0,0,0), 5'b00000, 5'b00000, 6'd25, 1'b0, 1'b1, "idle"});

        // Reset with every input requesting
        applyStimulus(1'b1, 5'b11111, pp(0,1,2,3,4), 5'b11111, 5'b0, 6'd25, 1'b0, 1'b0, "reset0");
        applyStimulus(1'b1, 5'b11111, pp(0,1,2,3,4), 5'b11111, 5'b0, 6'd25, 1'b0, 1'b0, "reset1");

        foreach (vecs[k])
            applyStimulus(1'b0, vecs[k].valid, vecs[k].port, vecs[k].tail, vecs[k].expGrant,
                          vecs[k].expSel, vecs[k].expSelValid, vecs[k].expErr, vecs[k].name);

        // Reset mid-packet must drop the lock input 1 holds on output 2
        applyStimulus(1'b0, 5'b00010, pp(0,2,0,0,0), 5'b00000, 5'b00010, 6'd11, 1'b1, 1'b1, "midHead");
        applyStimulus(1'b1, 5'b00010, pp(0,2,0,0,0), 5'b00000, 5'b00000, 6'd25, 1'b0, 1'b0, "midReset");
        applyStimulus(1'b0, 5'b01000, pp(0,0,0,2,0), 5'b01000, 5'b01000, 6'd13, 1'b1, 1'b0, "postReset");
        applyStimulus(1'b0, 5'b00000, pp(0,0,0,0,0), 5'b00000, 5'b00000, 6'd25, 1'b0, 1'b0, "drain");

        @(negedge clk);
        while (sbQ.size() > 0) begin
            exp_t e;
            e = sbQ.pop_front();
            checkOutput({e.name, " sel"}, 32'(bus.sel), 32'(e.sel));
            checkOutput({e.name, " sel_valid"}, 32'(bus.sel_valid), 32'(e.selValid));
            checkOutput({e.name, " err"}, 32'(bus.err), 32'(e.err));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
